// File: rtl/cache_next_arbiter_pkg.sv
// Shared types for the next-level cache port arbiter.
package cache_next_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RESP
    } arb_state_e;

    typedef enum bit {
        ARB_RR,
        ARB_FIXED
    } arb_mode_e;

    function automatic arb_mode_e arb_mode_from_int(input int unsigned mode);
        return (mode == 1) ? ARB_FIXED : ARB_RR;
    endfunction

endpackage

// File: rtl/cache_next_arbiter_rr_arbiter.sv
// Combinational request picker: round-robin after a pointer, or fixed lowest-index priority.
module cache_rr_arbiter
    import cache_next_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned IDXWIDTH     = $clog2(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] i_req,
    input  logic [IDXWIDTH-1:0]     i_ptr,
    input  arb_mode_e               i_mode,
    output logic [NUM_CHANNELS-1:0] o_grant,
    output logic [IDXWIDTH-1:0]     o_idx
);

    int w_j;

    // Candidates are visited lowest-priority first so the last hit is the winner.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_j     = 0;
        if (i_mode == ARB_FIXED) begin
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    o_grant    = '0;
                    o_grant[i] = 1'b1;
                    o_idx      = IDXWIDTH'(i);
                end
            end
        end else begin
            for (int k = NUM_CHANNELS; k >= 1; k--) begin
                w_j = (int'(i_ptr) + k) % NUM_CHANNELS;
                if (i_req[w_j]) begin
                    o_grant      = '0;
                    o_grant[w_j] = 1'b1;
                    o_idx        = IDXWIDTH'(w_j);
                end
            end
        end
    end

endmodule

// File: rtl/cache_next_arbiter.sv
// Merges several L1 next-level ports onto one memory port, one transaction at a time.
module cache_next_arbiter
    import cache_next_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned ADDRESSWIDTH = 32,
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned CNTWIDTH     = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CHANNELS-1:0]          req_valid,
    input  logic [NUM_CHANNELS-1:0]          req_write,
    input  logic [NUM_CHANNELS*ADDRESSWIDTH-1:0] req_addr,
    input  logic [NUM_CHANNELS*DATAWIDTH-1:0]    req_wdata,
    output logic [NUM_CHANNELS-1:0]          req_ready,
    output logic [NUM_CHANNELS-1:0]          resp_valid,
    output logic [DATAWIDTH-1:0]             resp_rdata,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_write,
    output logic [ADDRESSWIDTH-1:0]          mem_req_addr,
    output logic [DATAWIDTH-1:0]             mem_req_wdata,
    input  logic                             mem_resp_valid,
    input  logic [DATAWIDTH-1:0]             mem_resp_rdata,
    output logic [NUM_CHANNELS*CNTWIDTH-1:0] grant_count,
    output logic                             err_spurious
);

    localparam int unsigned IdxW = $clog2(NUM_CHANNELS);
    localparam arb_mode_e   Mode = arb_mode_from_int(ARB_MODE);

    arb_state_e                r_state, w_state_next;
    logic [IdxW-1:0]           r_ptr;
    logic [NUM_CHANNELS-1:0]   w_grant;
    logic [IdxW-1:0]           w_idx;
    logic                      w_accept;
    logic                      r_write;
    logic [ADDRESSWIDTH-1:0]   r_addr;
    logic [DATAWIDTH-1:0]      r_wdata;
    logic [NUM_CHANNELS-1:0]   r_owner;
    logic [NUM_CHANNELS-1:0]   r_resp_valid;
    logic [DATAWIDTH-1:0]      r_resp_rdata;
    logic [CNTWIDTH-1:0]       r_cnt [NUM_CHANNELS];
    logic                      r_err;

    cache_rr_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IDXWIDTH     (IdxW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_mode  (Mode),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Reset gating keeps req_ready low while reset is held, like every other output.
    assign w_accept  = (r_state == ARB_IDLE) && (|req_valid) && !reset;
    assign req_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ARB_IDLE:      if (w_accept)       w_state_next = ARB_ISSUE;
            ARB_ISSUE:     if (mem_req_ready)  w_state_next = ARB_WAIT_RESP;
            ARB_WAIT_RESP: if (mem_resp_valid) w_state_next = ARB_IDLE;
            default:                           w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_ptr        <= IdxW'(NUM_CHANNELS - 1);
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner      <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= '0;
            if (w_accept) begin
                r_write <= req_write[w_idx];
                r_addr  <= req_addr[w_idx*ADDRESSWIDTH +: ADDRESSWIDTH];
                r_wdata <= req_wdata[w_idx*DATAWIDTH +: DATAWIDTH];
                r_owner <= w_grant;
                if (Mode == ARB_RR) r_ptr <= w_idx;
            end
            if (mem_resp_valid) begin
                if (r_state == ARB_WAIT_RESP) begin
                    r_resp_valid <= r_owner;
                    r_resp_rdata <= mem_resp_rdata;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_accept && w_grant[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cnt
        assign grant_count[g*CNTWIDTH +: CNTWIDTH] = r_cnt[g];
    end

    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = (r_state == ARB_ISSUE);
    assign mem_req_write = r_write;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign err_spurious  = r_err;

endmodule

// File: tb/tb_cache_next_arbiter.sv
// Directed bench: three arbiter instances (round-robin, fixed, fixed with 2-bit counters)
// share one stimulus stream and a hand-driven memory handshake.
module tb_cache_next_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    logic [1:0]  rr_req_ready, rr_resp_valid, fx_req_ready, fx_resp_valid, st_req_ready, st_resp_valid;
    logic [31:0] rr_resp_rdata, fx_resp_rdata, st_resp_rdata;
    logic        rr_mem_req_valid, fx_mem_req_valid, st_mem_req_valid;
    logic        rr_mem_req_write, fx_mem_req_write, st_mem_req_write;
    logic [31:0] rr_mem_req_addr, fx_mem_req_addr, st_mem_req_addr;
    logic [31:0] rr_mem_req_wdata, fx_mem_req_wdata, st_mem_req_wdata;
    logic [31:0] rr_grant_count, fx_grant_count;
    logic [3:0]  st_grant_count;
    logic        rr_err_spurious, fx_err_spurious, st_err_spurious;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  c_rr_rdy, c_fx_rdy, c_st_rdy, c_rr_resp, c_fx_resp;
    logic        c_mem_valid;
    logic [31:0] c_mem_addr, c_rr_rdata;

    cache_next_arbiter #(.ARB_MODE(0), .CNTWIDTH(16)) u_rr (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rr_req_ready),
        .resp_valid(rr_resp_valid), .resp_rdata(rr_resp_rdata),
        .mem_req_valid(rr_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(rr_mem_req_write), .mem_req_addr(rr_mem_req_addr),
        .mem_req_wdata(rr_mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .grant_count(rr_grant_count),
        .err_spurious(rr_err_spurious)
    );

    cache_next_arbiter #(.ARB_MODE(1), .CNTWIDTH(16)) u_fx (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(fx_req_ready),
        .resp_valid(fx_resp_valid), .resp_rdata(fx_resp_rdata),
        .mem_req_valid(fx_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(fx_mem_req_write), .mem_req_addr(fx_mem_req_addr),
        .mem_req_wdata(fx_mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .grant_count(fx_grant_count),
        .err_spurious(fx_err_spurious)
    );

    cache_next_arbiter #(.ARB_MODE(1), .CNTWIDTH(2)) u_st (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(st_req_ready),
        .resp_valid(st_resp_valid), .resp_rdata(st_resp_rdata),
        .mem_req_valid(st_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(st_mem_req_write), .mem_req_addr(st_mem_req_addr),
        .mem_req_wdata(st_mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .grant_count(st_grant_count),
        .err_spurious(st_err_spurious)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One read: offer vld, accept, issue with ready high, one wait cycle, respond.
    task automatic txn(input logic [1:0] vld, input logic [63:0] addr, input logic [31:0] rdata);
        req_valid = vld;
        req_write = 2'b00;
        req_addr  = addr;
        req_wdata = '0;
        #1;
        c_rr_rdy = rr_req_ready;
        c_fx_rdy = fx_req_ready;
        c_st_rdy = st_req_ready;
        tick();
        req_valid     = '0;
        mem_req_ready = 1'b1;
        #1;
        c_mem_valid = rr_mem_req_valid;
        c_mem_addr  = rr_mem_req_addr;
        tick();
        mem_req_ready = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        tick();
        mem_resp_valid = 1'b0;
        c_rr_resp  = rr_resp_valid;
        c_fx_resp  = fx_resp_valid;
        c_rr_rdata = rr_resp_rdata;
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] exp_a;

        reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        #1;
        check_eq("reset mem_req_valid", rr_mem_req_valid, 1'b0);
        check_eq("reset resp_valid", rr_resp_valid, 2'b00);
        check_eq("reset grant_count", rr_grant_count, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Single read from ch1.
        txn(2'b10, {32'h0000_1000, 32'h0}, 32'hDEAD_BEEF);
        check_eq("single req_ready", c_rr_rdy, 2'b10);
        check_eq("single mem_req_valid", c_mem_valid, 1'b1);
        check_eq("single mem_req_addr", c_mem_addr, 32'h0000_1000);
        check_eq("single resp_valid", c_rr_resp, 2'b10);
        check_eq("single resp_rdata", c_rr_rdata, 32'hDEAD_BEEF);

        // Both channels requesting for four transactions.
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 32'h100 + i : 32'h200 + i;
            txn(2'b11, {32'h200 + i, 32'h100 + i}, 32'h1000 + i);
            check_eq($sformatf("rr grant %0d", i), c_rr_rdy, exp_g);
            check_eq($sformatf("rr addr %0d", i), c_mem_addr, exp_a);
            check_eq($sformatf("rr resp %0d", i), c_rr_resp, exp_g);
            check_eq($sformatf("rr rdata %0d", i), c_rr_rdata, 32'h1000 + i);
            check_eq($sformatf("fixed grant %0d", i), c_fx_rdy, 2'b01);
            check_eq($sformatf("fixed resp %0d", i), c_fx_resp, 2'b01);
        end

        txn(2'b01, {32'h0, 32'h300}, 32'h0);
        check_eq("ch0 only fixed", c_fx_rdy, 2'b01);
        check_eq("ch0 only rr", c_rr_rdy, 2'b01);
        txn(2'b10, {32'h400, 32'h0}, 32'h0);
        check_eq("ch1 after ch0 drops fixed", c_fx_rdy, 2'b10);
        check_eq("ch1 after ch0 drops rr", c_rr_rdy, 2'b10);
        check_eq("ch1 after ch0 drops sat", c_st_rdy, 2'b10);

        check_eq("rr grant_count", rr_grant_count, {16'd4, 16'd3});
        check_eq("fixed grant_count", fx_grant_count, {16'd2, 16'd5});
        check_eq("sat grant_count", st_grant_count, {2'd2, 2'd3});

        // Write from ch0 with five cycles of downstream backpressure.
        req_valid = 2'b01; req_write = 2'b01;
        req_addr  = {32'h0, 32'hA000_0000}; req_wdata = {32'h0, 32'h1234_5678};
        #1;
        check_eq("bp accept", rr_req_ready, 2'b01);
        tick();
        req_valid = 2'b11;
        req_write = 2'b10;
        req_addr  = {32'h5555_5555, 32'hBBBB_0000};
        req_wdata = {32'h6666_6666, 32'h7777_7777};
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp valid %0d", i), rr_mem_req_valid, 1'b1);
            check_eq($sformatf("bp addr %0d", i), rr_mem_req_addr, 32'hA000_0000);
            check_eq($sformatf("bp wdata %0d", i), rr_mem_req_wdata, 32'h1234_5678);
            check_eq($sformatf("bp write %0d", i), rr_mem_req_write, 1'b1);
            check_eq($sformatf("bp req_ready %0d", i), rr_req_ready, 2'b00);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq("bp wait mem_req_valid", rr_mem_req_valid, 1'b0);
        check_eq("bp wait req_ready", rr_req_ready, 2'b00);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h0;
        tick();
        mem_resp_valid = 1'b0;
        req_valid = 2'b00;
        check_eq("bp write ack resp_valid", rr_resp_valid, 2'b01);
        check_eq("sat after write", st_grant_count, {2'd2, 2'd3});

        // Stray memory response while idle.
        check_eq("err before", rr_err_spurious, 1'b0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check_eq("spurious err", rr_err_spurious, 1'b1);
        check_eq("spurious resp_valid", rr_resp_valid, 2'b00);
        tick();
        check_eq("spurious err sticky", rr_err_spurious, 1'b1);
        check_eq("spurious no issue", rr_mem_req_valid, 1'b0);

        // Reset while waiting for a response; ch0 must win first afterwards.
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        req_valid = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        check_eq("midreset req_ready", rr_req_ready, 2'b00);
        check_eq("midreset resp_valid", rr_resp_valid, 2'b00);
        check_eq("midreset mem_req_valid", rr_mem_req_valid, 1'b0);
        check_eq("midreset err", rr_err_spurious, 1'b0);
        check_eq("midreset grant_count", rr_grant_count, 32'h0);
        check_eq("midreset sat count", st_grant_count, 4'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("post reset priority", rr_req_ready, 2'b01);
        txn(2'b11, {32'h2000, 32'h3000}, 32'hCAFE_F00D);
        check_eq("post reset grant", c_rr_rdy, 2'b01);
        check_eq("post reset addr", c_mem_addr, 32'h3000);
        check_eq("post reset resp", c_rr_resp, 2'b01);
        check_eq("post reset rdata", c_rr_rdata, 32'hCAFE_F00D);
        check_eq("post reset count", rr_grant_count, {16'd0, 16'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
